// File: rtl/dac_spi_serializer.sv
// Dual-channel SPI DAC serializer: one 8-bit sine/cosine pair becomes two 16-bit frames
// shifted MSB first on shared sclk/cs_n. Samples offered while a frame is in flight are dropped.
module dac_spi_serializer #(
  parameter int CLK_DIV = 4,
  parameter int CS_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sin_data,
  input  logic [7:0] cos_data,
  output logic       sample_ready,
  output logic       sclk,
  output logic       cs_n,
  output logic       sdata_a,
  output logic       sdata_b,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt, div_nx;
  logic [7:0]  gap_cnt, gap_nx;
  logic [5:0]  tog_cnt, tog_nx;
  logic [15:0] sr_a, sr_a_nx, sr_b, sr_b_nx;
  logic [15:0] frame_a, frame_b;
  logic        sclk_nx, cs_n_nx, sdata_a_nx, sdata_b_nx, frame_done_nx, ready_nx;

  assign frame_a = {4'b0000, sin_data, 4'b0000};
  assign frame_b = {4'b0000, cos_data, 4'b0000};

  always_comb begin
    state_nx      = state;
    div_nx        = div_cnt;
    gap_nx        = gap_cnt;
    tog_nx        = tog_cnt;
    sr_a_nx       = sr_a;
    sr_b_nx       = sr_b;
    sclk_nx       = sclk;
    cs_n_nx       = cs_n;
    sdata_a_nx    = sdata_a;
    sdata_b_nx    = sdata_b;
    frame_done_nx = 1'b0;
    ready_nx      = sample_ready;
    case (state)
      IDLE: begin
        ready_nx   = 1'b1;
        sclk_nx    = 1'b1;
        cs_n_nx    = 1'b1;
        sdata_a_nx = 1'b0;
        sdata_b_nx = 1'b0;
        if (sample_valid && sample_ready) begin
          state_nx   = SHIFT;
          ready_nx   = 1'b0;
          cs_n_nx    = 1'b0;
          div_nx     = 8'd0;
          tog_nx     = 6'd0;
          sdata_a_nx = frame_a[15];
          sdata_b_nx = frame_b[15];
          sr_a_nx    = {frame_a[14:0], 1'b0};
          sr_b_nx    = {frame_b[14:0], 1'b0};
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nx  = 8'd0;
          tog_nx  = tog_cnt + 6'd1;
          sclk_nx = ~sclk;
          // tog_cnt is the number of toggles already made; odd means the next one rises
          if (tog_cnt == 6'd31) begin
            state_nx      = GAP;
            gap_nx        = 8'd0;
            sclk_nx       = 1'b1;
            cs_n_nx       = 1'b1;
            sdata_a_nx    = 1'b0;
            sdata_b_nx    = 1'b0;
            frame_done_nx = 1'b1;
          end else if (tog_cnt[0]) begin
            sdata_a_nx = sr_a[15];
            sdata_b_nx = sr_b[15];
            sr_a_nx    = {sr_a[14:0], 1'b0};
            sr_b_nx    = {sr_b[14:0], 1'b0};
          end
        end else begin
          div_nx = div_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
        end else begin
          gap_nx = gap_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      gap_cnt      <= 8'd0;
      tog_cnt      <= 6'd0;
      sr_a         <= 16'd0;
      sr_b         <= 16'd0;
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      sdata_a      <= 1'b0;
      sdata_b      <= 1'b0;
      frame_done   <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      state        <= state_nx;
      div_cnt      <= div_nx;
      gap_cnt      <= gap_nx;
      tog_cnt      <= tog_nx;
      sr_a         <= sr_a_nx;
      sr_b         <= sr_b_nx;
      sclk         <= sclk_nx;
      cs_n         <= cs_n_nx;
      sdata_a      <= sdata_a_nx;
      sdata_b      <= sdata_b_nx;
      frame_done   <= frame_done_nx;
      sample_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench: default-parameter instance plus a CLK_DIV=1/CS_HIGH=1 instance.
module tb_dac_spi_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic       sv0 = 1'b0, sv1 = 1'b0;
  logic [7:0] sin0 = 8'h00, cos0 = 8'h00, sin1 = 8'h00, cos1 = 8'h00;
  logic       rdy0, sclk0, cs0, sa0, sb0, fd0;
  logic       rdy1, sclk1, cs1, sa1, sb1, fd1;

  dac_spi_serializer dut0 (
    .clk(clk), .rst(rst), .sample_valid(sv0), .sin_data(sin0), .cos_data(cos0),
    .sample_ready(rdy0), .sclk(sclk0), .cs_n(cs0), .sdata_a(sa0), .sdata_b(sb0),
    .frame_done(fd0)
  );

  dac_spi_serializer #(.CLK_DIV(1), .CS_HIGH(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sv1), .sin_data(sin1), .cos_data(cos1),
    .sample_ready(rdy1), .sclk(sclk1), .cs_n(cs1), .sdata_a(sa1), .sdata_b(sb1),
    .frame_done(fd1)
  );

  // Passive observers, sampled mid-cycle; after edge N the value of cyc is N.
  int          bad0 = 0, falls0 = 0, low0 = 0, done_n0 = 0, done_cyc0 = -1, rdy_cyc0 = -1;
  logic [15:0] cap_a0 = 16'd0, cap_b0 = 16'd0;
  logic        p_sclk0 = 1'b1, p_cs0 = 1'b1, p_rdy0 = 1'b0;
  logic [15:0] qa0[$], qb0[$];
  int          acc_q0[$];
  logic [7:0]  acc_s0[$];

  always @(negedge clk) begin
    if (sclk0 !== p_sclk0 && p_cs0 === 1'b1 && cs0 === 1'b1) bad0++;
    if (p_sclk0 === 1'b1 && sclk0 === 1'b0 && cs0 === 1'b0) begin
      falls0++;
      cap_a0 = {cap_a0[14:0], sa0};
      cap_b0 = {cap_b0[14:0], sb0};
    end
    if (cs0 === 1'b0) low0++;
    if (fd0 === 1'b1) begin
      done_n0++;
      done_cyc0 = cyc;
      qa0.push_back(cap_a0);
      qb0.push_back(cap_b0);
    end
    if (rdy0 === 1'b1 && p_rdy0 !== 1'b1) rdy_cyc0 = cyc;
    if (sv0 === 1'b1 && rdy0 === 1'b1) begin
      acc_q0.push_back(cyc + 1);
      acc_s0.push_back(sin0);
    end
    p_sclk0 = sclk0;
    p_cs0   = cs0;
    p_rdy0  = rdy0;
  end

  int          bad1 = 0, falls1 = 0, low1 = 0, done_cyc1 = -1, rdy_cyc1 = -1;
  logic [15:0] cap_a1 = 16'd0, cap_b1 = 16'd0, last_a1 = 16'd0, last_b1 = 16'd0;
  logic        p_sclk1 = 1'b1, p_cs1 = 1'b1, p_rdy1 = 1'b0;

  always @(negedge clk) begin
    if (sclk1 !== p_sclk1 && p_cs1 === 1'b1 && cs1 === 1'b1) bad1++;
    if (p_sclk1 === 1'b1 && sclk1 === 1'b0 && cs1 === 1'b0) begin
      falls1++;
      cap_a1 = {cap_a1[14:0], sa1};
      cap_b1 = {cap_b1[14:0], sb1};
    end
    if (cs1 === 1'b0) low1++;
    if (fd1 === 1'b1) begin
      done_cyc1 = cyc;
      last_a1   = cap_a1;
      last_b1   = cap_b1;
    end
    if (rdy1 === 1'b1 && p_rdy1 !== 1'b1) rdy_cyc1 = cyc;
    p_sclk1 = sclk1;
    p_cs1   = cs1;
    p_rdy1  = rdy1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] s, input logic [7:0] c, output int e0);
    e0 = -1;
    sin0 = s; cos0 = c; sv0 = 1'b1;
    for (int i = 0; i < 400 && e0 < 0; i++) begin
      if (rdy0 === 1'b1) e0 = cyc + 1;
      tick();
    end
    sv0 = 1'b0;
    if (e0 < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL send0_timeout: got no accept want accept within 400 cycles");
    end
  endtask

  task automatic send1(input logic [7:0] s, input logic [7:0] c, output int e0);
    e0 = -1;
    sin1 = s; cos1 = c; sv1 = 1'b1;
    for (int i = 0; i < 400 && e0 < 0; i++) begin
      if (rdy1 === 1'b1) e0 = cyc + 1;
      tick();
    end
    sv1 = 1'b0;
    if (e0 < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL send1_timeout: got no accept want accept within 400 cycles");
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (cs0 !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b1) begin n_bad++; $display("FAIL rst_sclk: got %b want 1", sclk0); end
    n_cmp++; if ({sa0, sb0} !== 2'b00) begin n_bad++; $display("FAIL rst_sdata: got %b want 00", {sa0, sb0}); end
    n_cmp++; if (fd0 !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", fd0); end
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", rdy0); end
    tick(); tick();
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL rst_ready_held: got %b want 0", rdy0); end
    sin0 = 8'hA5; cos0 = 8'h3C; sv0 = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", rdy0); end
    n_cmp++; if (cs0 !== 1'b1) begin n_bad++; $display("FAIL rst_release_no_accept: cs_n got %b want 1", cs0); end
    sv0 = 1'b0;
    tick();
    n_cmp++; if (cs0 !== 1'b1) begin n_bad++; $display("FAIL idle_cs_n: got %b want 1", cs0); end
  endtask

  task automatic test_frame();
    int e0, f, l, d;
    f = falls0; l = low0; d = done_n0;
    send0(8'hA5, 8'h3C, e0);
    repeat (140) tick();
    n_cmp++; if (done_cyc0 !== e0 + 128) begin n_bad++; $display("FAIL frame_done_time: got %0d want %0d", done_cyc0, e0 + 128); end
    n_cmp++; if (done_n0 - d !== 1) begin n_bad++; $display("FAIL frame_done_width: got %0d want 1", done_n0 - d); end
    n_cmp++; if (rdy_cyc0 !== e0 + 132) begin n_bad++; $display("FAIL frame_ready_time: got %0d want %0d", rdy_cyc0, e0 + 132); end
    n_cmp++; if (qa0[$] !== 16'h0A50) begin n_bad++; $display("FAIL frame_a_bits: got %h want 0a50", qa0[$]); end
    n_cmp++; if (qb0[$] !== 16'h03C0) begin n_bad++; $display("FAIL frame_b_bits: got %h want 03c0", qb0[$]); end
    n_cmp++; if (falls0 - f !== 16) begin n_bad++; $display("FAIL frame_falls: got %0d want 16", falls0 - f); end
    n_cmp++; if (low0 - l !== 128) begin n_bad++; $display("FAIL frame_cs_low: got %0d want 128", low0 - l); end
    n_cmp++; if (bad0 !== 0) begin n_bad++; $display("FAIL frame_sclk_outside_cs: got %0d want 0", bad0); end
  endtask

  // Held-valid stream: a frame costs 132 cycles to ready plus the accepting edge.
  task automatic test_stream();
    int na, nq;
    na = acc_q0.size(); nq = qa0.size();
    sv0 = 1'b1;
    for (int i = 0; i < 399; i++) begin
      sin0 = 8'(cyc * 37 + 11);
      cos0 = ~sin0;
      tick();
    end
    sv0 = 1'b0;
    repeat (140) tick();
    n_cmp++; if (acc_q0.size() - na !== 3) begin n_bad++; $display("FAIL stream_accepts: got %0d want 3", acc_q0.size() - na); end
    n_cmp++; if (qa0.size() - nq !== 3) begin n_bad++; $display("FAIL stream_frames: got %0d want 3", qa0.size() - nq); end
    if (acc_q0.size() - na == 3 && qa0.size() - nq == 3) begin
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin
          n_cmp++;
          if (acc_q0[na + k] - acc_q0[na + k - 1] !== 133) begin
            n_bad++; $display("FAIL stream_spacing%0d: got %0d want 133", k, acc_q0[na + k] - acc_q0[na + k - 1]);
          end
        end
        n_cmp++;
        if (qa0[nq + k] !== {4'h0, acc_s0[na + k], 4'h0}) begin
          n_bad++; $display("FAIL stream_a%0d: got %h want %h", k, qa0[nq + k], {4'h0, acc_s0[na + k], 4'h0});
        end
        n_cmp++;
        if (qb0[nq + k] !== {4'h0, ~acc_s0[na + k], 4'h0}) begin
          n_bad++; $display("FAIL stream_b%0d: got %h want %h", k, qb0[nq + k], {4'h0, ~acc_s0[na + k], 4'h0});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0, d, b;
    send0(8'h5A, 8'hC3, e0);
    d = done_n0;
    for (int i = 0; i < 200 && cyc < e0 + 50; i++) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (cs0 !== 1'b1) begin n_bad++; $display("FAIL midrst_cs_n: got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b1) begin n_bad++; $display("FAIL midrst_sclk: got %b want 1", sclk0); end
    #3 rst = 1'b0;
    b = bad0;
    @(posedge clk); #1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", rdy0); end
    repeat (150) tick();
    n_cmp++; if (done_n0 !== d) begin n_bad++; $display("FAIL midrst_no_done: got %0d want %0d", done_n0, d); end
    n_cmp++; if (bad0 !== b) begin n_bad++; $display("FAIL midrst_no_sclk: got %0d want %0d", bad0, b); end
  endtask

  task automatic test_fast();
    int e0, f, l;
    f = falls1; l = low1;
    send1(8'hFF, 8'h00, e0);
    repeat (40) tick();
    n_cmp++; if (last_a1 !== 16'h0FF0) begin n_bad++; $display("FAIL fast_a_bits: got %h want 0ff0", last_a1); end
    n_cmp++; if (last_b1 !== 16'h0000) begin n_bad++; $display("FAIL fast_b_bits: got %h want 0000", last_b1); end
    n_cmp++; if (low1 - l !== 32) begin n_bad++; $display("FAIL fast_cs_low: got %0d want 32", low1 - l); end
    n_cmp++; if (falls1 - f !== 16) begin n_bad++; $display("FAIL fast_falls: got %0d want 16", falls1 - f); end
    n_cmp++; if (done_cyc1 !== e0 + 32) begin n_bad++; $display("FAIL fast_done_time: got %0d want %0d", done_cyc1, e0 + 32); end
    n_cmp++; if (rdy_cyc1 !== e0 + 33) begin n_bad++; $display("FAIL fast_ready_time: got %0d want %0d", rdy_cyc1, e0 + 33); end
    send1(8'h81, 8'h7E, e0);
    repeat (40) tick();
    n_cmp++; if ({last_a1, last_b1} !== 32'h0810_07E0) begin n_bad++; $display("FAIL fast_frame2: got %h want 081007e0", {last_a1, last_b1}); end
    n_cmp++; if (bad1 !== 0) begin n_bad++; $display("FAIL fast_sclk_outside_cs: got %0d want 0", bad1); end
  endtask

  task automatic test_extremes();
    int e0, f, l;
    f = falls0; l = low0;
    send0(8'h00, 8'hFF, e0);
    repeat (140) tick();
    n_cmp++; if (qa0[$] !== 16'h0000) begin n_bad++; $display("FAIL ext_a_bits: got %h want 0000", qa0[$]); end
    n_cmp++; if (qb0[$] !== 16'h0FF0) begin n_bad++; $display("FAIL ext_b_bits: got %h want 0ff0", qb0[$]); end
    n_cmp++; if (falls0 - f !== 16) begin n_bad++; $display("FAIL ext_falls: got %0d want 16", falls0 - f); end
    n_cmp++; if (low0 - l !== 128) begin n_bad++; $display("FAIL ext_cs_low: got %0d want 128", low0 - l); end
    n_cmp++; if (bad0 !== 0) begin n_bad++; $display("FAIL ext_sclk_outside_cs: got %0d want 0", bad0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stream();
    test_reset_mid();
    test_fast();
    test_extremes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
